// File: rtl/ysyx_25050148_lsu.sv
// RV32I load/store unit: one valid/ready word-addressed memory transaction per
// request, with lane steering for stores and sign/zero extension for loads.
module ysyx_25050148_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_wen,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            func3_q, func3_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  fault_q, fault_d;

  logic [1:0]            req_off;
  logic                  req_fault;
  logic [3:0]            req_mask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] rd_ext;

  // Legality, alignment and lane steering of the incoming request.
  always_comb begin
    req_off   = alu_result[1:0];
    req_fault = 1'b0;
    req_mask  = 4'b0000;
    req_wdata = store_data;
    if (req_wen) begin
      case (func3)
        3'd0: begin
          req_mask  = 4'b0001 << req_off;
          req_wdata = {4{store_data[7:0]}};
        end
        3'd1: begin
          req_fault = req_off[0];
          req_mask  = 4'b0011 << req_off;
          req_wdata = {2{store_data[15:0]}};
        end
        3'd2: begin
          req_fault = |req_off;
          req_mask  = 4'b1111;
        end
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (func3)
        3'd0, 3'd4: req_fault = 1'b0;
        3'd1, 3'd5: req_fault = req_off[0];
        3'd2:       req_fault = |req_off;
        default:    req_fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (func3_q)
      3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    rd_ext = {24'd0, rd_byte};
      3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      3'd5:    rd_ext = {16'd0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    func3_d     = func3_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            state_d     = DONE;
            fault_d     = 1'b1;
            load_data_d = '0;
          end else begin
            state_d = REQ;
            addr_d  = alu_result;
            func3_d = func3;
            wen_d   = req_wen;
            wdata_d = req_wdata;
            wmask_d = req_wen ? req_mask : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d     = DONE;
          fault_d     = 1'b0;
          load_data_d = wen_q ? '0 : rd_ext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      func3_q     <= 3'd0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= 4'b0000;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      func3_q     <= func3_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  assign done      = (state_q == DONE);
  assign stall     = req_valid & ~done;
  assign load_data = load_data_q;
  assign fault     = fault_q;
  assign mem_req   = (state_q == REQ);
  assign mem_wen   = mem_req & wen_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wmask = mem_req ? wmask_q : 4'b0000;

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Directed bench for ysyx_25050148_lsu; completions are matched against a
// scoreboard of expected load_data/fault pushed when each request is driven.
module tb_ysyx_25050148_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wen;
  logic [2:0]  func3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic        flt;
    bit          chk_data;
  } exp_t;

  exp_t sbq[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  ysyx_25050148_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wen(req_wen),
    .func3(func3), .alu_result(alu_result), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data), .fault(fault),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request on a negedge and services memory with the given ready delay.
  task automatic apply_stimulus(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                                input logic [31:0] exp_data, input logic exp_fault,
                                input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                                input logic [31:0] exp_wdata, input bit hold_after);
    int   cyc;
    int   req_cycles;
    bit   seen_done;
    exp_t e;
    exp_t got;
    @(negedge clk);
    check_output("accept_idle_req", mem_req, 1'b0);
    check_output("accept_idle_done", done, 1'b0);
    req_valid  = 1'b1;
    req_wen    = wen;
    func3      = f3;
    alu_result = addr;
    store_data = sd;
    mem_rdata  = rdata;
    mem_ready  = 1'b0;
    e.data = exp_data;
    e.flt = exp_fault;
    e.chk_data = !wen || exp_fault;
    sbq.push_back(e);
    #1 check_output("stall_c0", stall, 1'b1);
    cyc = 0;
    req_cycles = 0;
    seen_done = 0;
    while (!seen_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen_done = 1;
        check_output("done_cycle", cyc, exp_fault ? 1 : delay + 2);
        check_output("stall_done", stall, 1'b0);
        if (sbq.size() == 0) begin
          check_output("sb_empty_at_done", 32'd0, 32'd1);
        end else begin
          got = sbq.pop_front();
          check_output("fault", fault, got.flt);
          if (got.chk_data) check_output("load_data", load_data, got.data);
        end
        if (!exp_fault) check_output("req_cycles", req_cycles, delay + 1);
      end else begin
        check_output("stall_busy", stall, 1'b1);
        if (exp_fault) check_output("fault_noreq", mem_req, 1'b0);
        else begin
          check_output("mem_req", mem_req, 1'b1);
          check_output("mem_addr", mem_addr, exp_addr);
          check_output("mem_wen", mem_wen, wen);
          check_output("mem_wmask", mem_wmask, exp_mask);
          if (wen) check_output("mem_wdata", mem_wdata, exp_wdata);
          mem_ready = (req_cycles >= delay);
          req_cycles++;
        end
      end
    end
    if (!seen_done) check_output("done_timeout", 32'd0, 32'd1);
    mem_ready = 1'b0;
    if (!hold_after) req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    func3 = 3'd0;
    alu_result = '0;
    store_data = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    check_output("rst_done", done, 1'b0);
    check_output("rst_fault", fault, 1'b0);
    check_output("rst_mem_req", mem_req, 1'b0);
    check_output("rst_mem_wen", mem_wen, 1'b0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_mem_wmask", mem_wmask, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2,
                   32'hDEAD_BEEF, 1'b0, 32'h8000_0010, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0,
                   32'hFFFF_FF80, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1,
                   32'h0000_0080, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0,
                   32'hFFFF_8001, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b0, 3'd5, 32'h8000_0000, 32'h0, 32'h8001_8FFF, 0,
                   32'h0000_8FFF, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b1, 3'd1, 32'h8000_0006, 32'h0000_ABCD, 32'h0, 1,
                   32'h0, 1'b0, 32'h8000_0004, 4'b1100, 32'hABCD_ABCD, 0);
    apply_stimulus(1'b1, 3'd0, 32'h8000_0101, 32'h1234_5678, 32'h0, 0,
                   32'h0, 1'b0, 32'h8000_0100, 4'b0010, 32'h7878_7878, 0);
    apply_stimulus(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h1111_1111, 0,
                   32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b1, 3'd3, 32'h8000_0000, 32'h5555_5555, 32'h0, 0,
                   32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    apply_stimulus(1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 0,
                   32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 0);
    check_output("fault_hold", fault, 1'b1);

    // Back-to-back loads with req_valid never dropped between them.
    apply_stimulus(1'b0, 3'd2, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 0,
                   32'hCAFE_F00D, 1'b0, 32'h8000_0040, 4'b0000, 32'h0, 1);
    apply_stimulus(1'b0, 3'd2, 32'h8000_0044, 32'h0, 32'h0BAD_CAFE, 0,
                   32'h0BAD_CAFE, 1'b0, 32'h8000_0044, 4'b0000, 32'h0, 0);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = 1'b0;
    func3 = 3'd2;
    alu_result = 32'h8000_0020;
    mem_ready = 1'b0;
    @(negedge clk);
    check_output("rst_pre_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid_mem_req", mem_req, 1'b0);
    check_output("rst_mid_done", done, 1'b0);
    check_output("rst_mid_load_data", load_data, 32'd0);
    check_output("rst_mid_mem_addr", mem_addr, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_req", mem_req, 1'b0);
    check_output("post_rst_done", done, 1'b0);
    apply_stimulus(1'b1, 3'd2, 32'h8000_0030, 32'h89AB_CDEF, 32'h0, 0,
                   32'h0, 1'b0, 32'h8000_0030, 4'b1111, 32'h89AB_CDEF, 0);

    check_output("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
